// File: rtl/fifo_pop_packer_pkg.sv
// Shared defaults, word type and control-state encoding for the FIFO pop/pack datapath.
package fifo_pop_packer_pkg;

    localparam int unsigned WIDTH_DEF = 32'd8;
    localparam int unsigned PACK_DEF  = 32'd4;

    typedef bit [WIDTH_DEF-1:0] fifo_unit;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

endpackage

// File: rtl/fifo_pop_packer_out_reg.sv
// Output holding register for packed beats: valid/ready handshake with same-cycle reload.
module pack_out_reg #(
    parameter int unsigned DATA_W = 32'd32,
    parameter int unsigned KEEP_W = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_valid,
    output logic              free
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [KEEP_W-1:0] keep_r;

    // Free when empty or being drained this cycle, so back-to-back beats need no bubble.
    assign free      = ~valid_r | out_ready;
    assign out_data  = data_r;
    assign out_keep  = keep_r;
    assign out_valid = valid_r;

    // Beat register: reload, drain on handshake, otherwise hold stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            keep_r  <= {KEEP_W{1'b0}};
        end else if (load && free) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            keep_r  <= load_keep;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/fifo_pop_packer.sv
// Pops a sync FIFO, packs PACK consecutive words into one wide beat and emits it on valid/ready,
// with a flush request that pushes out a partially filled beat.
module fifo_pop_packer
    import fifo_pop_packer_pkg::*;
#(
    parameter int unsigned Width = WIDTH_DEF,
    parameter int unsigned PACK  = PACK_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ept,
    output logic                  pop,
    input  logic                  valid,
    input  logic [Width-1:0]      r_data,
    output logic [PACK*Width-1:0] out_data,
    output logic [PACK-1:0]       out_keep,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  err_unexp
);

    localparam int unsigned     CNT_W    = $clog2(PACK + 32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);

    pack_state_e                 state_r;
    pack_state_e                 state_nxt_s;
    logic [CNT_W-1:0]            acc_cnt_r;
    logic [PACK-1:0][Width-1:0]  acc_data_r;
    logic                        inflight_r;
    logic                        armed_r;
    logic                        err_r;
    logic                        capture_s;
    logic                        unexp_s;
    logic                        full_s;
    logic                        flush_xfer_s;
    logic                        xfer_s;
    logic                        out_free_s;
    logic [PACK*Width-1:0]       xfer_data_s;
    logic [PACK-1:0]             xfer_keep_s;

    // armed_r masks the first cycle after reset release: no pops, stray valid ignored.
    assign capture_s    = armed_r & valid & inflight_r;
    assign unexp_s      = armed_r & valid & ~inflight_r;
    assign full_s       = (acc_cnt_r == CNT_FULL);
    assign flush_xfer_s = (state_r == FLUSH) && (acc_cnt_r != {CNT_W{1'b0}}) && !inflight_r;
    assign xfer_s       = out_free_s & (full_s | flush_xfer_s);
    assign err_unexp    = err_r;

    // Pop only while filling and the accumulator plus the in-flight word leave room; a flush request blocks new pops at once.
    always_comb begin
        pop = 1'b0;
        if (armed_r && !ept && (state_r == FILL) && !flush &&
            (({1'b0, acc_cnt_r} + {{CNT_W{1'b0}}, inflight_r}) < {1'b0, CNT_FULL})) begin
            pop = 1'b1;
        end else begin
            pop = 1'b0;
        end
    end

    // Beat assembly: lanes below acc_cnt carry data, the rest are zero with keep cleared.
    always_comb begin
        xfer_data_s = {(PACK*Width){1'b0}};
        xfer_keep_s = {PACK{1'b0}};
        for (int i = 0; i < int'(PACK); i++) begin
            if (CNT_W'(i) < acc_cnt_r) begin
                xfer_data_s[i*Width +: Width] = acc_data_r[i];
                xfer_keep_s[i]                = 1'b1;
            end else begin
                xfer_data_s[i*Width +: Width] = {Width{1'b0}};
                xfer_keep_s[i]                = 1'b0;
            end
        end
    end

    // Flush control: wait out any in-flight word, then finish directly or with the partial beat.
    always_comb begin
        state_nxt_s = state_r;
        flush_done  = 1'b0;
        case (state_r)
            FILL: begin
                if (flush) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            FLUSH: begin
                if (inflight_r) begin
                    state_nxt_s = FLUSH;
                end else if (acc_cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = FILL;
                    flush_done  = 1'b1;
                end else if (xfer_s) begin
                    state_nxt_s = FILL;
                    flush_done  = 1'b1;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = FILL;
                flush_done  = 1'b0;
            end
        endcase
    end

    // Control registers: state, accumulator fill level, in-flight tracking and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= FILL;
            acc_cnt_r  <= {CNT_W{1'b0}};
            inflight_r <= 1'b0;
            armed_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            armed_r    <= 1'b1;
            inflight_r <= pop | (inflight_r & ~valid);
            if (xfer_s) begin
                acc_cnt_r <= {CNT_W{1'b0}};
            end else if (capture_s) begin
                acc_cnt_r <= acc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                acc_cnt_r <= acc_cnt_r;
            end
            if (unexp_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Accumulator lanes: returned word lands in lane acc_cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_data_r <= {(PACK*Width){1'b0}};
        end else begin
            for (int i = 0; i < int'(PACK); i++) begin
                if (capture_s && (acc_cnt_r == CNT_W'(i))) begin
                    acc_data_r[i] <= r_data;
                end
            end
        end
    end

    pack_out_reg #(
        .DATA_W (PACK*Width),
        .KEEP_W (PACK)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (xfer_s),
        .load_data (xfer_data_s),
        .load_keep (xfer_keep_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .free      (out_free_s)
    );

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Self-checking bench for fifo_pop_packer: a queue-based FIFO model feeds the DUT and beats are
// checked against the word stream grouped PACK at a time.
module tb_fifo_pop_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ept;
    logic        pop;
    logic        valid;
    logic [7:0]  r_data;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic        flush_done;
    logic        err_unexp;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] beat_data_q[$];
    logic [3:0]  beat_keep_q[$];
    logic        pend_v;
    logic [7:0]  pend_d;
    int          pop_cnt;
    int          done_cnt;
    logic        last_pop;
    logic        last_done;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic [7:0]  w;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    int          pushed;

    typedef struct {
        int          n;
        logic [7:0]  words[4];
        logic        fl;
        int          nbeats;
        logic [31:0] d;
        logic [3:0]  k;
    } vec_t;
    vec_t vec[6];

    always #5 clk = ~clk;

    fifo_pop_packer #(.Width(8), .PACK(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ept        (ept),
        .pop        (pop),
        .valid      (valid),
        .r_data     (r_data),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .err_unexp  (err_unexp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. The FIFO model answers a pop with valid next cycle.
    task automatic tick(input logic fl);
        valid  = pend_v;
        r_data = pend_d;
        pend_v = 1'b0;
        ept    = (fifo_q.size() == 0);
        flush  = fl;
        #1;
        last_pop  = pop;
        last_done = flush_done;
        if (pop) begin
            pop_cnt++;
            if (fifo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_on_empty: got pop=1, expected 0");
            end else begin
                pend_d = fifo_q.pop_front();
                pend_v = 1'b1;
            end
        end
        if (prev_stall) chk("hold_stable", {out_valid, out_keep, out_data}, {1'b1, prev_keep, prev_data});
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_keep  = out_keep;
        if (out_valid && out_ready) begin
            beat_data_q.push_back(out_data);
            beat_keep_q.push_back(out_keep);
        end
        if (flush_done) done_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pop"}, pop, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_keep"}, out_keep, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
        chk({tag, "_err_unexp"}, err_unexp, 0);
    endtask

    task automatic clear_obs();
        beat_data_q.delete();
        beat_keep_q.delete();
        pop_cnt  = 0;
        done_cnt = 0;
    endtask

    // Asserted at a falling edge: outputs must clear at once; the bench drops the in-flight word too.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_reset_outputs(tag);
        fifo_q.delete();
        pend_v     = 1'b0;
        valid      = 1'b0;
        flush      = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; ept = 1'b1; valid = 1'b0; r_data = 8'h00; flush = 1'b0; out_ready = 1'b1;
        pend_v = 1'b0; pend_d = 8'h00; prev_stall = 1'b0; prev_data = 32'h0; prev_keep = 4'h0;
        pop_cnt = 0; done_cnt = 0; last_pop = 1'b0; last_done = 1'b0;

        vec[0] = '{4, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 1, 32'h44332211, 4'b1111};
        vec[1] = '{3, '{8'hA1, 8'hA2, 8'hA3, 8'h00}, 1'b1, 1, 32'h00A3A2A1, 4'b0111};
        vec[2] = '{1, '{8'h5C, 8'h00, 8'h00, 8'h00}, 1'b1, 1, 32'h0000005C, 4'b0001};
        vec[3] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 0, 32'h00000000, 4'b0000};
        vec[4] = '{2, '{8'hC3, 8'h3C, 8'h00, 8'h00}, 1'b1, 1, 32'h00003CC3, 4'b0011};
        vec[5] = '{4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1, 1, 32'hEFBEADDE, 4'b1111};

        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0);

        // Table vectors: push words, optionally flush once drained, compare the beat.
        for (int t = 0; t < 6; t++) begin
            clear_obs();
            out_ready = 1'b1;
            for (int j = 0; j < vec[t].n; j++) fifo_q.push_back(vec[t].words[j]);
            repeat (12) tick(1'b0);
            if (vec[t].fl) begin
                tick(1'b1);
                repeat (6) tick(1'b0);
            end
            chk($sformatf("tbl%0d_beats", t), beat_data_q.size(), vec[t].nbeats);
            if (beat_data_q.size() > 0) begin
                chk($sformatf("tbl%0d_data", t), beat_data_q[0], vec[t].d);
                chk($sformatf("tbl%0d_keep", t), beat_keep_q[0], vec[t].k);
            end
            chk($sformatf("tbl%0d_pops", t), pop_cnt, vec[t].n);
            chk($sformatf("tbl%0d_done", t), done_cnt, vec[t].fl ? 1 : 0);
        end

        // Backpressure: two beats' worth of words with the sink stalled.
        clear_obs();
        out_ready = 1'b0;
        for (int j = 1; j <= 8; j++) fifo_q.push_back(8'(j));
        repeat (20) tick(1'b0);
        chk("bp_pop_stall", pop_cnt, 8);
        chk("bp_valid_held", out_valid, 1);
        chk("bp_data_held", out_data, 32'h04030201);
        out_ready = 1'b1;
        repeat (10) tick(1'b0);
        chk("bp_beats", beat_data_q.size(), 2);
        if (beat_data_q.size() == 2) begin
            chk("bp_beat0", beat_data_q[0], 32'h04030201);
            chk("bp_beat1", beat_data_q[1], 32'h08070605);
            chk("bp_keep1", beat_keep_q[1], 4'b1111);
        end

        // Flush with an empty accumulator while the FIFO holds data: no pops until it completes.
        clear_obs();
        fifo_q.push_back(8'h61);
        fifo_q.push_back(8'h62);
        tick(1'b1);
        chk("fl_pop_req_cycle", last_pop, 0);
        chk("fl_done_req_cycle", last_done, 0);
        tick(1'b0);
        chk("fl_pop_flush_state", last_pop, 0);
        chk("fl_done_next", last_done, 1);
        repeat (8) tick(1'b0);
        tick(1'b1);
        repeat (6) tick(1'b0);
        chk("fl_beats", beat_data_q.size(), 1);
        if (beat_data_q.size() == 1) chk("fl_beat", {beat_keep_q[0], beat_data_q[0]}, {4'b0011, 32'h00006261});
        chk("fl_done_cnt", done_cnt, 2);

        // Stray valid with nothing in flight: sticky error, word dropped.
        clear_obs();
        pend_v = 1'b1;
        pend_d = 8'h5A;
        tick(1'b0);
        chk("unexp_err_set", err_unexp, 1);
        for (int j = 0; j < 4; j++) fifo_q.push_back(8'h71 + 8'(j));
        repeat (12) tick(1'b0);
        chk("unexp_beats", beat_data_q.size(), 1);
        if (beat_data_q.size() == 1) chk("unexp_beat", beat_data_q[0], 32'h74737271);
        chk("unexp_err_sticky", err_unexp, 1);

        // Reset with two words accumulated and one in flight.
        clear_obs();
        for (int j = 0; j < 4; j++) fifo_q.push_back(8'h81 + 8'(j));
        for (int i = 0; i < 20 && pop_cnt < 3; i++) tick(1'b0);
        chk("mid_pops_before_reset", pop_cnt, 3);
        do_reset("mid_reset");
        pend_v = 1'b1;
        pend_d = 8'hEE;
        tick(1'b0);
        chk("post_reset_stray_err", err_unexp, 0);
        clear_obs();
        for (int j = 0; j < 4; j++) fifo_q.push_back(8'h91 + 8'(j));
        repeat (12) tick(1'b0);
        chk("post_reset_beats", beat_data_q.size(), 1);
        if (beat_data_q.size() == 1) chk("post_reset_beat", beat_data_q[0], 32'h94939291);

        // Random stream with random sink stalls, drained by a final flush.
        clear_obs();
        exp_q.delete();
        pushed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (pushed < 62 && $urandom_range(0, 2) != 0) begin
                w = 8'($urandom_range(0, 255));
                fifo_q.push_back(w);
                exp_q.push_back(w);
                pushed++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(1'b0);
        end
        out_ready = 1'b1;
        repeat (10) tick(1'b0);
        tick(1'b1);
        repeat (8) tick(1'b0);
        chk("rand_beats", beat_data_q.size(), 16);
        for (int b = 0; b < beat_data_q.size(); b++) begin
            exp_d = 32'h0;
            exp_k = 4'h0;
            for (int l = 0; l < 4; l++) begin
                if (exp_q.size() > 0) begin
                    exp_d[l*8 +: 8] = exp_q.pop_front();
                    exp_k[l]        = 1'b1;
                end
            end
            chk($sformatf("rand_data%0d", b), beat_data_q[b], exp_d);
            chk($sformatf("rand_keep%0d", b), beat_keep_q[b], exp_k);
        end
        chk("rand_all_delivered", exp_q.size(), 0);
        chk("rand_pops", pop_cnt, 62);
        chk("rand_done", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_pop_packer.md
Name: fifo_pop_packer

Overview:
- Downstream consumer of the sync FIFO read port: issues pop while the FIFO is non-empty and local space exists.
- Captures each returned word and packs PACK consecutive words into one wide beat.
- Presents beats on a valid/ready output interface, with flush support for partial beats.
- Sits between the FIFO and the wide-datapath sink.

Parameters:
Width, 8, FIFO word width in bits (same value as FIFO `Width)
PACK, 4, words per output beat (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
ept  input  1  FIFO empty flag
pop  output  1  FIFO pop request
valid  input  1  FIFO read-data valid, one cycle after accepted pop
r_data  input  Width  FIFO read data, qualified by valid
out_data  output  PACK*Width  packed beat, word 0 in [Width-1:0]
out_keep  output  PACK  per-word lane valid mask
out_valid  output  1  beat valid
out_ready  input  1  sink accepts beat when out_valid&&out_ready
flush  input  1  single-cycle request to emit partial beat
flush_done  output  1  single-cycle pulse when flush completes
err_unexp  output  1  sticky: valid seen with no pop in flight

Behaviour:
- Reset (reset=0, async) values: pop=0, out_valid=0, out_data=0, out_keep=0, flush_done=0, err_unexp=0. Internal acc_cnt=0, inflight=0, flush pending cleared, state=FILL.
- Reset mid-operation discards the accumulator, the output register and any in-flight word. A valid in the first cycle after reset release is ignored; err_unexp is not set by it.
- pop (combinational from registers and ept):
  - pop = ~ept && state==FILL && (acc_cnt + inflight < PACK).
  - Accepted pop sets inflight=1; inflight clears when valid arrives.
  - At most one pop in flight.
- Word capture on valid:
  - Write r_data into lane acc_cnt, then acc_cnt++.
  - If inflight=0 when valid arrives, the word is dropped and err_unexp=1, held until reset.
- Transfer accumulator -> output register when the output register is empty or drained this cycle (out_valid&&out_ready). Conditions:
  - Full: acc_cnt==PACK. out_keep=all ones.
  - Flush: acc_cnt>0, state==FLUSH, inflight==0. out_keep = (1<<acc_cnt)-1; unused lanes are zero.
  - On transfer: acc_cnt=0 and out_valid=1 next cycle.
- Output register: holds out_data and out_keep stable while out_valid&&~out_ready. It clears out_valid on handshake unless a new transfer loads in the same cycle, giving back-to-back beats with no bubble.
- State machine:
  - FILL -> FLUSH when flush=1.
  - FLUSH: no new pops; wait inflight==0.
  - FLUSH, acc_cnt==0 -> FILL with flush_done=1.
  - FLUSH, acc_cnt>0 -> transfer the partial beat (when output register free) -> FILL with flush_done=1 in the transfer cycle.
  - flush while already in FLUSH is ignored.
- Simultaneous events:
  - flush in the same cycle a full transfer occurs: the full beat goes out first, then FLUSH sees acc_cnt==0 and completes immediately.
  - valid and flush in the same cycle: the word is captured before the flush evaluation.
- Throughput: at least PACK words per PACK+1 cycles with out_ready=1; no word is lost or reordered under out_ready backpressure.
- Latency: the last word's valid produces out_valid 2 cycles later when the output register is free.

Decomposition:
- Shared package: Width default, the fifo_unit typedef (bit[Width-1:0]), and the state enum {FILL, FLUSH}.
- One natural sub-module: pack_out_reg, the output holding register with valid/ready and same-cycle reload.

Test Plan (Width=8, PACK=4):
- Push 0x11,0x22,0x33,0x44 into the FIFO, out_ready=1 -> exactly one beat: out_data=0x44332211, out_keep=4'b1111; pop asserted exactly 4 times.
- Push 8 words 0x01..0x08, out_ready=0 for 20 cycles then 1 -> pop stalls after 8 words. Beats 0x04030201 then 0x08070605 in order; out_data stable while stalled.
- Push 0xA1,0xA2,0xA3, flush once FIFO empty -> beat 0x00A3A2A1, out_keep=4'b0111, flush_done pulses once.
- flush with acc_cnt=0 and FIFO empty -> no beat, flush_done next cycle; assert a pop issued in the flush cycle on a non-empty FIFO is suppressed.
- Assert reset=0 mid-beat (2 words accumulated, 1 in flight) -> all outputs zero immediately. After release, push 4 new words -> first beat contains only the new words.
- Drive valid with no pop outstanding -> err_unexp=1 and stays 1 until reset; acc_cnt unchanged.
